// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised CPU core: opcode values, the
// sequencer state encoding and instruction field-slicing helpers.
package cpu_pkg;

    // Opcodes held in the three MSBs of each instruction word
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;
    localparam logic [2:0] OP_SHR  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    // Sequencer states; the encoding is visible on state_out
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Widest register-index field the helpers handle; callers zero-extend
    // their instruction word to MAX_IW and narrow the result to RW bits.
    localparam int MAX_RW = 8;
    localparam int MAX_IW = 3 + 3 * MAX_RW;

    // Field idx counts from the LSB end: 0 = rs2, 1 = rs1, 2 = rd
    function automatic logic [MAX_RW-1:0] ir_field(input logic [MAX_IW-1:0] ir,
                                                   input int rw, input int idx);
        logic [MAX_IW-1:0] s;
        s = (ir >> (idx * rw)) & ((MAX_IW'(1) << rw) - MAX_IW'(1));
        return s[MAX_RW-1:0];
    endfunction

    function automatic logic [2:0] ir_opcode(input logic [MAX_IW-1:0] ir, input int rw);
        logic [MAX_IW-1:0] s;
        s = ir >> (3 * rw);
        return s[2:0];
    endfunction

    function automatic logic [MAX_RW-1:0] ir_rd(input logic [MAX_IW-1:0] ir, input int rw);
        return ir_field(ir, rw, 2);
    endfunction

    function automatic logic [MAX_RW-1:0] ir_rs1(input logic [MAX_IW-1:0] ir, input int rw);
        return ir_field(ir, rw, 1);
    endfunction

    function automatic logic [MAX_RW-1:0] ir_rs2(input logic [MAX_IW-1:0] ir, input int rw);
        return ir_field(ir, rw, 0);
    endfunction

endpackage

// File: rtl/cpu_alu_param.sv
// Combinational ALU for the CPU core. All results wrap modulo 2^DATA_W;
// carry reports ADD carry-out, SUB borrow, or the bit shifted out.
module cpu_alu_param
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // The extra MSB of diff is set exactly when a < b (borrow)
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Select the operation; HALT and anything unlisted produce zero
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_core_param.sv
// Parametrised multi-cycle CPU core: host-loadable register file and
// instruction memory, driven by a LOAD/FETCH/EXEC/DONE sequencer.
// Each instruction spends one cycle in FETCH and one in EXEC.
// Optional macro CPU_FLAGS_EN adds zero_flag / carry_flag outputs.
module cpu_core_param
    import cpu_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int NREGS      = 4,
    parameter  int IMEM_DEPTH = 16,
    localparam int RW         = $clog2(NREGS),
    localparam int AW         = $clog2(IMEM_DEPTH),
    localparam int IW         = 3 + 3 * RW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clr,
    input  logic              imem_wr_en,
    input  logic [AW-1:0]     imem_addr,
    input  logic [IW-1:0]     imem_wdata,
    input  logic              reg_wr_en,
    input  logic [RW-1:0]     reg_addr,
    input  logic [DATA_W-1:0] reg_wdata,
    input  logic [RW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     pc_out,
`ifdef CPU_FLAGS_EN
    output logic              zero_flag,
    output logic              carry_flag,
`endif
    output logic [1:0]        state_out
);

    state_t            state;
    logic [AW-1:0]     pc;
    logic [IW-1:0]     ir;
    logic [DATA_W-1:0] regs [NREGS];
    logic [IW-1:0]     imem [IMEM_DEPTH];

    logic [2:0]        opcode;
    logic [RW-1:0]     rd;
    logic [RW-1:0]     rs1;
    logic [RW-1:0]     rs2;
    logic [DATA_W-1:0] alu_result;
`ifdef CPU_FLAGS_EN
    logic              alu_carry;
`endif

    // Decode the latched instruction; operands are read in EXEC so an
    // instruction whose rd matches a source sees the pre-write value.
    assign opcode = ir_opcode(MAX_IW'(ir), RW);
    assign rd     = RW'(ir_rd(MAX_IW'(ir), RW));
    assign rs1    = RW'(ir_rs1(MAX_IW'(ir), RW));
    assign rs2    = RW'(ir_rs2(MAX_IW'(ir), RW));

    cpu_alu_param #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode (opcode),
        .a      (regs[rs1]),
        .b      (regs[rs2]),
        .result (alu_result),
`ifdef CPU_FLAGS_EN
        .carry  (alu_carry)
`else
        .carry  ()
`endif
    );

    assign rd_data   = regs[rd_addr];
    assign busy      = (state == ST_FETCH) || (state == ST_EXEC);
    assign done      = (state == ST_DONE);
    assign pc_out    = pc;
    assign state_out = state;

    // Sequencer, host writes, instruction latch and register writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
            pc    <= '0;
            ir    <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= '0;
`ifdef CPU_FLAGS_EN
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
`endif
        end else begin
            case (state)
                ST_LOAD: begin
                    // Host writes land even in the cycle that starts the run
                    if (imem_wr_en) imem[imem_addr] <= imem_wdata;
                    if (reg_wr_en)  regs[reg_addr]  <= reg_wdata;
                    if (start) begin
                        state <= ST_FETCH;
                        pc    <= '0;
`ifdef CPU_FLAGS_EN
                        zero_flag  <= 1'b0;
                        carry_flag <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    ir    <= imem[pc];
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (opcode == OP_HALT) begin
                        state <= ST_DONE;
                    end else begin
                        regs[rd] <= alu_result;
`ifdef CPU_FLAGS_EN
                        zero_flag  <= (alu_result == '0);
                        carry_flag <= alu_carry;
`endif
                        // Falling off the end of memory finishes the run
                        if (pc == {AW{1'b1}}) begin
                            state <= ST_DONE;
                        end else begin
                            pc    <= pc + AW'(1);
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    // start has priority over clr
                    if (start) begin
                        state <= ST_FETCH;
                        pc    <= '0;
`ifdef CPU_FLAGS_EN
                        zero_flag  <= 1'b0;
                        carry_flag <= 1'b0;
`endif
                    end else if (clr) begin
                        state <= ST_LOAD;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule
